// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - frame command decoder and word memory behind the 18-bit SPI slave
// Optional: define SPI_RAM_ADDR_AUTO_INC_EN to post-increment wr_addr/rd_addr after each access.
module spi_ram_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic [DATA_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W+1:0] ram_data_out,
  output logic              tx_valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_RD_ISSUE = 3'd3;
  localparam logic [2:0] S_RD_RESP  = 3'd4;

  localparam logic [1:0] CMD_SET_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE     = 2'b01;
  localparam logic [1:0] CMD_SET_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ      = 2'b11;

  logic [2:0]        state;
  logic              rx_valid_d;
  logic              detect;
  logic [1:0]        cmd_reg;
  logic [DATA_W-1:0] pay_reg;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Addresses past the populated depth fold back into the array.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    if (MEM_DEPTH >= (1 << ADDR_W))
      return a;
    else
      return ADDR_W'(int'(a) % MEM_DEPTH);
  endfunction

`ifdef SPI_RAM_ADDR_AUTO_INC_EN
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(MEM_DEPTH - 1))
      return '0;
    else
      return a + 1'b1;
  endfunction
`endif

  // Only the rising edge of the slave's level counts as a frame.
  assign detect = rx_valid & ~rx_valid_d;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      rx_valid_d   <= 1'b0;
      cmd_reg      <= '0;
      pay_reg      <= '0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      ram_data_out <= '1;
      tx_valid     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      tx_valid   <= 1'b0;
      if (detect && busy)
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (detect) begin
            cmd_reg <= rx_data[DATA_W+1:DATA_W];
            pay_reg <= rx_data[DATA_W-1:0];
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (cmd_reg)
            CMD_SET_WADDR: begin
              wr_addr <= wrap_addr(pay_reg[ADDR_W-1:0]);
              state   <= S_IDLE;
            end
            CMD_WRITE:     state <= S_WRITE;
            CMD_SET_RADDR: begin
              rd_addr <= wrap_addr(pay_reg[ADDR_W-1:0]);
              state   <= S_IDLE;
            end
            CMD_READ:      state <= S_RD_ISSUE;
            default:       state <= S_IDLE;
          endcase
        end
        S_WRITE: begin
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
          wr_addr <= next_addr(wr_addr);
`endif
          state <= S_IDLE;
        end
        S_RD_ISSUE: state <= S_RD_RESP;
        S_RD_RESP: begin
          ram_data_out <= {2'b11, rd_q};
          tx_valid     <= 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
          rd_addr <= next_addr(rd_addr);
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset; reset pulls state out of WRITE so a pending write is lost.
  always_ff @(posedge sys_clock) begin
    if (state == S_WRITE)
      mem[wr_addr] <= pay_reg;
    if (state == S_RD_ISSUE)
      rd_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - randomized bench for spi_ram_ctrl against a frame-level reference model
// Optional: define SPI_RAM_ADDR_AUTO_INC_EN to check the address auto-increment build.
module tb_spi_ram_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          sys_clock = 1'b0;
  logic          reset     = 1'b1;
  logic [DW+1:0] rx_data   = '0;
  logic          rx_valid  = 1'b0;
  logic [DW+1:0] ram_data_out;
  logic          tx_valid;
  logic          busy;
  logic          overrun;

  spi_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .sys_clock    (sys_clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .ram_data_out (ram_data_out),
    .tx_valid     (tx_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 sys_clock = ~sys_clock;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  always @(posedge sys_clock) edges <= edges + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame-level semantics with a per-command occupancy window in edges.
  typedef struct {
    logic [17:0] data;
    bit          known;
    int          edge_no;
  } resp_t;

  resp_t       exp_q[$];
  logic [15:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int          m_wa;
  int          m_ra;
  bit          m_overrun;
  int          next_free;

  function automatic void model_reset();
    m_wa      = 0;
    m_ra      = 0;
    m_overrun = 0;
    next_free = 0;
    exp_q.delete();
  endfunction

  function automatic void model_frame(input logic [17:0] f, input int det);
    int cmd;
    int dur;
    logic [7:0] a;
    cmd = int'(f[17:16]);
    a   = f[7:0];
    case (cmd)
      0, 2:    dur = 2;
      1:       dur = 3;
      default: dur = 4;
    endcase
    if (det < next_free) begin
      m_overrun = 1;
      return;
    end
    next_free = det + dur;
    case (cmd)
      0: m_wa = int'(a) % DEPTH;
      1: begin
        m_mem[m_wa]   = f[15:0];
        m_known[m_wa] = 1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
        m_wa = (m_wa + 1) % DEPTH;
`endif
      end
      2: m_ra = int'(a) % DEPTH;
      default: begin
        exp_q.push_back('{data: {2'b11, m_mem[m_ra]}, known: m_known[m_ra], edge_no: det + 3});
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
        m_ra = (m_ra + 1) % DEPTH;
`endif
      end
    endcase
  endfunction

  // Called at posedge+1; the frame is detected on the next edge.
  task automatic send(input logic [17:0] f, input int hold, input int gap);
    rx_data  = f;
    rx_valid = 1'b1;
    model_frame(f, edges + 1);
    repeat (hold) @(posedge sys_clock);
    #1 rx_valid = 1'b0;
    repeat (gap) @(posedge sys_clock);
    #1;
  endtask

  logic  prev_tx = 1'b0;
  resp_t mon_r;

  always @(negedge sys_clock) begin
    if (tx_valid) begin
      check("tx_single", 32'(prev_tx), 32'd0);
      if (exp_q.size() == 0) begin
        check("tx_unexpected", 32'd1, 32'd0);
      end else begin
        mon_r = exp_q.pop_front();
        check("tx_edge", 32'(edges), 32'(mon_r.edge_no));
        if (mon_r.known)
          check("tx_data", 32'(ram_data_out), 32'(mon_r.data));
      end
    end
    prev_tx <= tx_valid;
  end

  initial begin
    logic [1:0]  cmd;
    logic [15:0] pay;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge sys_clock);
    #1;
    check("rst_data", 32'(ram_data_out), 32'h3ffff);
    check("rst_tx", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(posedge sys_clock);
    #1;

    send(18'h00005, 1, 3);
    send(18'h1ABCD, 1, 3);
    send(18'h20005, 1, 3);
    send(18'h30000, 1, 6);
    check("basic_data", 32'(ram_data_out), 32'h3ABCD);

    send(18'h00003, 1, 2);
    send(18'h1AAAA, 10, 2);
    send(18'h20003, 1, 2);
    send(18'h30000, 1, 5);
    check("held_data", 32'(ram_data_out), 32'h3AAAA);
    check("held_overrun", 32'(overrun), 32'd0);

    send(18'h30000, 1, 1);
    send(18'h00077, 1, 6);
    check("ovr_set", 32'(overrun), 32'd1);
    send(18'h20005, 1, 2);
    send(18'h30000, 1, 6);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_read_after", 32'(ram_data_out), 32'h3ABCD);

    rx_data  = 18'h30000;
    rx_valid = 1'b1;
    @(posedge sys_clock);
    #1 rx_valid = 1'b0;
    @(posedge sys_clock);
    #1;
    check("rdissue_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_data", 32'(ram_data_out), 32'h3ffff);
    check("midrst_tx", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    @(posedge sys_clock);
    #1 reset = 1'b0;
    model_reset();
    repeat (6) @(posedge sys_clock);
    #1;

`ifdef SPI_RAM_ADDR_AUTO_INC_EN
    send(18'h000FF, 1, 2);
    send(18'h10111, 1, 3);
    send(18'h10222, 1, 3);
    send(18'h200FF, 1, 2);
    send(18'h30000, 1, 5);
    check("inc_rd0", 32'(ram_data_out), 32'h30111);
    send(18'h30000, 1, 5);
    check("inc_rd1", 32'(ram_data_out), 32'h30222);
`endif

    for (int i = 0; i < 300; i++) begin
      cmd = 2'($urandom_range(0, 3));
      pay = 16'($urandom);
      if (cmd == 2'b00 || cmd == 2'b10)
        pay[7:0] = 8'($urandom_range(0, 15));
      send({cmd, pay}, $urandom_range(1, 3), $urandom_range(1, 4));
    end

    repeat (8) @(posedge sys_clock);
    #1;
    check("final_overrun", 32'(overrun), 32'(m_overrun));
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
